// File: rtl/cd_pkg.sv
`default_nettype none
// ============================================================
// cd_pkg : shared types and constants for the NeoGeo CD DMA block
// Revision : 1.0
// ============================================================
package cd_pkg;

  typedef enum logic [3:0] {
    IDLE,
    REQ,
    GRANT,
    RD_A,
    RD_W,
    WR_A,
    WR_W,
    NEXT,
    REL,
    FINISH
  } dma_state_t;

  typedef enum logic [1:0] {
    BR_IDLE,
    BR_REQ,
    BR_OWN
  } br_state_t;

  localparam logic DMA_MODE_COPY = 1'b0;
  localparam logic DMA_MODE_FILL = 1'b1;

  // CPU-visible DMA register map; each parameter register is 32 bits wide
  localparam logic [23:0] CD_REG_DMA_CTRL  = 24'hFF0061;
  localparam logic [23:0] CD_REG_DMA_SRC   = 24'hFF0064;
  localparam logic [23:0] CD_REG_DMA_DEST  = 24'hFF0068;
  localparam logic [23:0] CD_REG_DMA_VALUE = 24'hFF006C;
  localparam logic [23:0] CD_REG_DMA_COUNT = 24'hFF0070;
  localparam logic [23:0] CD_REG_DMA_LAST  = 24'hFF0073;

endpackage
`default_nettype wire

// File: rtl/cd_dma_busreq.sv
`default_nettype none
// ============================================================
// cd_dma_busreq : 68K bus arbitration handshake (nBR / nBG / nBGACK)
// Revision      : 1.0
// ============================================================
module cd_dma_busreq
  import cd_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_release,
  input  logic i_nbg,
  input  logic i_nas_cpu,
  output logic o_nbr,
  output logic o_nbgack,
  output logic o_bus_owned
);

  br_state_t r_state;
  br_state_t w_next;
  logic      r_nbr;
  logic      r_nbgack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= BR_IDLE;
      r_nbr    <= 1'b1;
      r_nbgack <= 1'b1;
    end else begin
      r_state  <= w_next;
      r_nbr    <= (w_next != BR_REQ);
      r_nbgack <= (w_next != BR_OWN);
    end
  end

  // Take the bus only once the CPU has granted it and finished its own cycle
  always_comb begin
    w_next = r_state;
    case (r_state)
      BR_IDLE: if (i_req) w_next = BR_REQ;
      BR_REQ:  if (!i_nbg && i_nas_cpu) w_next = BR_OWN;
      BR_OWN:  if (i_release) w_next = BR_IDLE;
      default: w_next = BR_IDLE;
    endcase
  end

  assign o_nbr       = r_nbr;
  assign o_nbgack    = r_nbgack;
  assign o_bus_owned = !r_nbgack;

endmodule
`default_nettype wire

// File: rtl/cd_dma_ctrl.sv
`default_nettype none
// ============================================================
// cd_dma_ctrl : NeoGeo CD bus-master DMA sequencer (copy / fill)
// Revision    : 1.0
// ============================================================
module cd_dma_ctrl
  import cd_pkg::*;
#(
  parameter int DTACK_TIMEOUT = 64,
  parameter int CNT_W         = 24
) (
  input  logic        CLK_68KCLK,
  input  logic        nRESET,
  input  logic        DMA_START,
  input  logic        DMA_ABORT,
  input  logic        DMA_MODE,
  input  logic [31:0] DMA_SOURCE,
  input  logic [31:0] DMA_DEST,
  input  logic [31:0] DMA_VALUE,
  input  logic [31:0] DMA_COUNT,
  output logic        nBR,
  input  logic        nBG,
  input  logic        nAS_CPU,
  output logic        nBGACK,
  output logic [22:0] DMA_ADDR,
  output logic [15:0] DMA_DOUT,
  input  logic [15:0] DMA_DIN,
  output logic        DMA_DRIVE,
  output logic        DMA_DOE,
  output logic        nDMA_AS,
  output logic        nDMA_UDS,
  output logic        nDMA_LDS,
  output logic        DMA_RW,
  input  logic        nDTACK,
  output logic        DMA_BUSY,
  output logic        DMA_DONE,
  output logic        DMA_ERR
);

  localparam int TMR_W = $clog2(DTACK_TIMEOUT) + 1;

  dma_state_t       r_state;
  dma_state_t       w_next;
  logic [22:0]      r_src;
  logic [22:0]      r_dst;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mode;
  logic [15:0]      r_value;
  logic [TMR_W-1:0] r_timer;
  logic [22:0]      r_addr;
  logic [15:0]      r_dout;
  logic             r_rw;
  logic             r_strb_n;
  logic             r_doe;
  logic             r_drive;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             w_req;
  logic             w_rel;
  logic             w_bus_owned;
  logic             w_tmo;
  logic             w_fill;
  logic             w_unused;

  assign w_tmo  = (r_timer == TMR_W'(DTACK_TIMEOUT - 1));
  assign w_fill = (r_mode == DMA_MODE_FILL);
  assign w_unused = ^{DMA_SOURCE[31:24], DMA_SOURCE[0], DMA_DEST[31:24], DMA_DEST[0],
                      DMA_VALUE[31:16], DMA_COUNT[31:CNT_W]};

  cd_dma_busreq u_busreq (
    .clk         (CLK_68KCLK),
    .rst_n       (nRESET),
    .i_req       (w_req),
    .i_release   (w_rel),
    .i_nbg       (nBG),
    .i_nas_cpu   (nAS_CPU),
    .o_nbr       (nBR),
    .o_nbgack    (nBGACK),
    .o_bus_owned (w_bus_owned)
  );

  always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
    if (!nRESET) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_req  = 1'b0;
    w_rel  = 1'b0;
    case (r_state)
      IDLE:   if (DMA_START) w_next = (DMA_COUNT[CNT_W-1:0] == '0) ? FINISH : REQ;
      REQ: begin
        w_req = 1'b1;
        if (w_bus_owned) w_next = GRANT;
      end
      GRANT:  w_next = w_fill ? WR_A : RD_A;
      RD_A:   w_next = RD_W;
      RD_W:   if (!nDTACK) w_next = WR_A; else if (w_tmo) w_next = REL;
      WR_A:   w_next = WR_W;
      WR_W:   if (!nDTACK) w_next = NEXT; else if (w_tmo) w_next = REL;
      NEXT: begin
        if (r_cnt == CNT_W'(1) || DMA_ABORT) w_next = REL;
        else                                 w_next = w_fill ? WR_A : RD_A;
      end
      REL: begin
        w_rel  = 1'b1;
        w_next = FINISH;
      end
      FINISH: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Bus outputs are registered so strobes only move at state boundaries
  always_ff @(posedge CLK_68KCLK or negedge nRESET) begin
    if (!nRESET) begin
      r_src    <= '0;
      r_dst    <= '0;
      r_cnt    <= '0;
      r_mode   <= DMA_MODE_COPY;
      r_value  <= '0;
      r_timer  <= '0;
      r_addr   <= '0;
      r_dout   <= '0;
      r_rw     <= 1'b1;
      r_strb_n <= 1'b1;
      r_doe    <= 1'b0;
      r_drive  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (DMA_START) begin
          r_src   <= DMA_SOURCE[23:1];
          r_dst   <= DMA_DEST[23:1];
          r_cnt   <= DMA_COUNT[CNT_W-1:0];
          r_mode  <= DMA_MODE;
          r_value <= DMA_VALUE[15:0];
          r_busy  <= 1'b1;
          r_err   <= 1'b0;
        end
        GRANT: r_drive <= 1'b1;
        RD_A: begin
          r_addr   <= r_src;
          r_rw     <= 1'b1;
          r_strb_n <= 1'b0;
          r_timer  <= '0;
        end
        RD_W: begin
          if (!nDTACK) begin
            r_dout   <= DMA_DIN;
            r_strb_n <= 1'b1;
          end else if (w_tmo) begin
            r_strb_n <= 1'b1;
            r_err    <= 1'b1;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        WR_A: begin
          r_addr   <= r_dst;
          r_rw     <= 1'b0;
          r_doe    <= 1'b1;
          r_strb_n <= 1'b0;
          r_timer  <= '0;
          if (w_fill) r_dout <= r_value;
        end
        WR_W: begin
          if (!nDTACK || w_tmo) begin
            r_strb_n <= 1'b1;
            r_doe    <= 1'b0;
            r_rw     <= 1'b1;
            if (nDTACK) r_err <= 1'b1;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        NEXT: begin
          r_cnt <= r_cnt - CNT_W'(1);
          r_dst <= r_dst + 23'd1;
          if (!w_fill) r_src <= r_src + 23'd1;
        end
        REL: r_drive <= 1'b0;
        FINISH: begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign DMA_ADDR  = r_addr;
  assign DMA_DOUT  = r_dout;
  assign DMA_RW    = r_rw;
  assign nDMA_AS   = r_strb_n;
  assign nDMA_UDS  = r_strb_n;
  assign nDMA_LDS  = r_strb_n;
  assign DMA_DOE   = r_doe;
  assign DMA_DRIVE = r_drive;
  assign DMA_BUSY  = r_busy;
  assign DMA_DONE  = r_done;
  assign DMA_ERR   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cd_dma_ctrl.sv
`default_nettype none
// ============================================================
// tb_cd_dma_ctrl : self-checking bench for the CD DMA sequencer
// Revision       : 1.0
// ============================================================
module tb_cd_dma_ctrl;

  logic        CLK_68KCLK = 1'b0;
  logic        nRESET     = 1'b0;
  logic        DMA_START  = 1'b0;
  logic        DMA_ABORT  = 1'b0;
  logic        DMA_MODE   = 1'b0;
  logic [31:0] DMA_SOURCE = '0;
  logic [31:0] DMA_DEST   = '0;
  logic [31:0] DMA_VALUE  = '0;
  logic [31:0] DMA_COUNT  = '0;
  logic        nBR;
  logic        nBG        = 1'b1;
  logic        nAS_CPU    = 1'b1;
  logic        nBGACK;
  logic [22:0] DMA_ADDR;
  logic [15:0] DMA_DOUT;
  logic [15:0] DMA_DIN;
  logic        DMA_DRIVE, DMA_DOE, nDMA_AS, nDMA_UDS, nDMA_LDS, DMA_RW;
  logic        nDTACK;
  logic        DMA_BUSY, DMA_DONE, DMA_ERR;

  cd_dma_ctrl #(.DTACK_TIMEOUT(64), .CNT_W(24)) dut (
    .CLK_68KCLK (CLK_68KCLK), .nRESET   (nRESET),   .DMA_START (DMA_START),
    .DMA_ABORT  (DMA_ABORT),  .DMA_MODE (DMA_MODE), .DMA_SOURCE(DMA_SOURCE),
    .DMA_DEST   (DMA_DEST),   .DMA_VALUE(DMA_VALUE), .DMA_COUNT(DMA_COUNT),
    .nBR        (nBR),        .nBG      (nBG),      .nAS_CPU   (nAS_CPU),
    .nBGACK     (nBGACK),     .DMA_ADDR (DMA_ADDR), .DMA_DOUT  (DMA_DOUT),
    .DMA_DIN    (DMA_DIN),    .DMA_DRIVE(DMA_DRIVE), .DMA_DOE  (DMA_DOE),
    .nDMA_AS    (nDMA_AS),    .nDMA_UDS (nDMA_UDS), .nDMA_LDS  (nDMA_LDS),
    .DMA_RW     (DMA_RW),     .nDTACK   (nDTACK),   .DMA_BUSY  (DMA_BUSY),
    .DMA_DONE   (DMA_DONE),   .DMA_ERR  (DMA_ERR)
  );

  always #5 CLK_68KCLK = ~CLK_68KCLK;

  int tests = 0;
  int fails = 0;

  // Memory slave: read data indexed by word offset from the transfer source
  logic [15:0] rdmem [256];
  logic [22:0] src_base = '0;
  logic        dtack_en = 1'b1;
  int          waits    = 0;
  int          as_cnt   = 0;
  assign DMA_DIN = rdmem[8'(DMA_ADDR - src_base)];
  assign nDTACK  = !(dtack_en && !nDMA_AS && (as_cnt >= waits));
  always @(posedge CLK_68KCLK) as_cnt <= nDMA_AS ? 0 : as_cnt + 1;

  // CPU arbiter model: grants grant_delay cycles after nBR, drops nBG on nBGACK
  int grant_delay = 2;
  int gcnt        = 0;
  always @(posedge CLK_68KCLK) begin
    if (!nBGACK) begin
      nBG <= 1'b1; gcnt <= 0;
    end else if (!nBR) begin
      if (gcnt >= grant_delay) nBG <= 1'b0;
      else gcnt <= gcnt + 1;
    end else begin
      nBG <= 1'b1; gcnt <= 0;
    end
  end

  // Bus monitor
  int          cyc = 0, rd_n = 0, done_n = 0, as_low = 0, proto_err = 0;
  bit          nbr_seen = 0;
  logic [22:0] wq_a[$];
  logic [15:0] wq_d[$];
  int          wq_c[$];
  always @(posedge CLK_68KCLK) begin
    cyc++;
    if (nRESET) begin
      if (!nDMA_AS) as_low++;
      if (nDMA_UDS !== nDMA_AS || nDMA_LDS !== nDMA_AS) proto_err++;
      if ((!nDMA_AS && !DMA_DRIVE) || (DMA_DRIVE && nBGACK)) proto_err++;
      if (!nDMA_AS && !nDTACK) begin
        if (DMA_RW) begin
          rd_n++;
          if (DMA_DOE) proto_err++;
        end else begin
          wq_a.push_back(DMA_ADDR); wq_d.push_back(DMA_DOUT); wq_c.push_back(cyc);
          if (!DMA_DOE) proto_err++;
        end
      end
      if (DMA_DONE) done_n++;
      if (!nBR) nbr_seen = 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    rd_n = 0; done_n = 0; as_low = 0; proto_err = 0; nbr_seen = 0;
    wq_a.delete(); wq_d.delete(); wq_c.delete();
  endtask

  task automatic do_start(input logic mode, input logic [31:0] src, input logic [31:0] dst,
                          input logic [31:0] val, input logic [31:0] cnt);
    @(negedge CLK_68KCLK);
    DMA_MODE = mode; DMA_SOURCE = src; DMA_DEST = dst; DMA_VALUE = val; DMA_COUNT = cnt;
    DMA_START = 1'b1;
    @(negedge CLK_68KCLK);
    DMA_START = 1'b0;
    DMA_MODE = 1'($urandom); DMA_SOURCE = $urandom; DMA_DEST = $urandom;
    DMA_VALUE = $urandom; DMA_COUNT = $urandom;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int k = 0; k < budget && done_n == 0; k++) @(negedge CLK_68KCLK);
    repeat (4) @(negedge CLK_68KCLK);
    check({tag, "_done_pulses"}, done_n, 1);
  endtask

  // Reference model: word i goes to dst+i (mod 2^23) carrying VALUE or the i-th source word
  task automatic expect_xfer(input string tag, input logic mode, input logic [31:0] dst,
                             input logic [31:0] val, input int n, input bit gap);
    logic [22:0] d;
    d = dst[23:1];
    check({tag, "_nwrites"}, wq_a.size(), n);
    check({tag, "_nreads"}, rd_n, mode ? 0 : n);
    for (int i = 0; i < n && i < wq_a.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), {9'd0, wq_a[i]}, {9'd0, 23'(d + 23'(i))});
      check($sformatf("%s_data%0d", tag, i), {16'd0, wq_d[i]},
            {16'd0, mode ? val[15:0] : rdmem[i % 256]});
      if (gap && i > 0)
        check($sformatf("%s_gap%0d", tag, i), wq_c[i] - wq_c[i-1], mode ? 3 : 5);
    end
    check({tag, "_proto"}, proto_err, 0);
    check({tag, "_idle_bus"}, {nBGACK, nBR, DMA_DRIVE, DMA_BUSY}, 4'b1100);
  endtask

  task automatic run_xfer(input string tag, input logic mode, input logic [31:0] src,
                          input logic [31:0] dst, input logic [31:0] val,
                          input logic [31:0] cnt, input int n, input bit gap);
    clear_mon();
    src_base = src[23:1];
    do_start(mode, src, dst, val, cnt);
    check({tag, "_busy"}, DMA_BUSY, 1);
    wait_done(tag, 3000);
    expect_xfer(tag, mode, dst, val, n, gap);
    check({tag, "_err"}, DMA_ERR, 0);
  endtask

  initial begin
    int  k;
    bit  found;
    bit  low_seen;
    logic mode;
    logic [31:0] src, dst, val;
    int  cnt;

    for (int i = 0; i < 256; i++) rdmem[i] = 16'($urandom);
    repeat (3) @(negedge CLK_68KCLK);
    check("reset_ctrl", {nBR, nBGACK, nDMA_AS, nDMA_UDS, nDMA_LDS, DMA_RW,
                         DMA_DRIVE, DMA_DOE, DMA_BUSY, DMA_DONE, DMA_ERR}, 11'b11111100000);
    check("reset_addr", {9'd0, DMA_ADDR}, 0);
    check("reset_dout", {16'd0, DMA_DOUT}, 0);
    nRESET = 1'b1;
    repeat (2) @(negedge CLK_68KCLK);

    // Directed fill and copy
    run_xfer("fill4", 1'b1, 32'h0, 32'h0010_0000, 32'h0000_ABCD, 32'd4, 4, 1);
    rdmem[0] = 16'h1111; rdmem[1] = 16'h2222; rdmem[2] = 16'h3333;
    run_xfer("copy3", 1'b0, 32'h0020_0000, 32'h00E0_0000, 32'h0, 32'd3, 3, 1);
    // Count bits above CNT_W are ignored
    run_xfer("cnt_hi", 1'b1, 32'h0, 32'h0040_0010, 32'h5A5A, 32'h0100_0003, 3, 1);

    // Randomised transfers, first one wraps the destination past 2^23 words
    for (int it = 0; it < 6; it++) begin
      mode = 1'($urandom);
      src  = $urandom;
      dst  = (it == 0) ? 32'h00FF_FFFC : $urandom;
      val  = $urandom;
      cnt  = $urandom_range(1, 6);
      waits = (it < 2) ? 0 : $urandom_range(0, 2);
      grant_delay = $urandom_range(0, 3);
      for (int i = 0; i < 256; i++) rdmem[i] = 16'($urandom);
      run_xfer($sformatf("rnd%0d", it), mode, src, dst, val, cnt, cnt, waits == 0);
    end
    waits = 0; grant_delay = 2;

    // Zero count: no arbitration, DONE two cycles after START
    clear_mon();
    @(negedge CLK_68KCLK);
    DMA_MODE = 1'b1; DMA_COUNT = 32'h0100_0000; DMA_START = 1'b1;
    k = 0;
    do begin
      @(negedge CLK_68KCLK);
      DMA_START = 1'b0;
      k++;
    end while (!DMA_DONE && k < 10);
    check("cnt0_latency", k, 2);
    repeat (4) @(negedge CLK_68KCLK);
    check("cnt0_nbr", nbr_seen, 0);
    check("cnt0_done", done_n, 1);

    // DTACK timeout on the first read
    clear_mon();
    dtack_en = 1'b0;
    do_start(1'b0, 32'h0000_2000, 32'h0000_4000, 32'h0, 32'd2);
    wait_done("tmo", 400);
    check("tmo_as_cycles", as_low, 64);
    check("tmo_err", DMA_ERR, 1);
    check("tmo_writes", wq_a.size(), 0);
    check("tmo_bus", {nBGACK, nDMA_AS, DMA_DRIVE, DMA_BUSY}, 4'b1100);
    dtack_en = 1'b1;
    run_xfer("after_tmo", 1'b1, 32'h0, 32'h0000_8000, 32'h0000_1234, 32'd1, 1, 0);

    // START while busy is ignored
    clear_mon();
    do_start(1'b1, 32'h0, 32'h0012_0000, 32'h0000_C0DE, 32'd3);
    repeat (3) @(negedge CLK_68KCLK);
    DMA_DEST = 32'h0034_0000; DMA_COUNT = 32'd7; DMA_START = 1'b1;
    @(negedge CLK_68KCLK);
    DMA_START = 1'b0;
    wait_done("busy_start", 500);
    expect_xfer("busy_start", 1'b1, 32'h0012_0000, 32'h0000_C0DE, 3, 1);

    // Abort during the second write of ten
    clear_mon();
    do_start(1'b1, 32'h0, 32'h0030_0000, 32'h0000_BEEF, 32'd10);
    found = 0;
    for (k = 0; k < 200 && !found; k++) begin
      @(negedge CLK_68KCLK);
      if (!nDMA_AS && !DMA_RW && wq_a.size() == 1) found = 1;
    end
    check("abort_2nd_write_seen", found, 1);
    DMA_ABORT = 1'b1;
    wait_done("abort", 200);
    DMA_ABORT = 1'b0;
    expect_xfer("abort", 1'b1, 32'h0030_0000, 32'h0000_BEEF, 2, 1);

    // Abort held from before the grant still moves one word
    DMA_ABORT = 1'b1;
    run_xfer("abort_early", 1'b1, 32'h0, 32'h0031_0000, 32'h0000_7777, 32'd5, 1, 0);
    DMA_ABORT = 1'b0;

    // CPU cycle in progress delays the grant; then reset in the middle of a write
    clear_mon();
    grant_delay = 0;
    nAS_CPU = 1'b0;
    do_start(1'b1, 32'h0, 32'h0010_0000, 32'h0000_9999, 32'd20);
    found = 0;
    for (k = 0; k < 50 && !found; k++) begin
      @(negedge CLK_68KCLK);
      if (!nBG) found = 1;
    end
    check("nbg_fell", found, 1);
    low_seen = 0;
    repeat (5) begin
      @(negedge CLK_68KCLK);
      if (!nBGACK || !nDMA_AS) low_seen = 1;
    end
    check("grant_held_off", low_seen, 0);
    nAS_CPU = 1'b1;
    found = 0;
    for (k = 0; k < 5 && !found; k++) begin
      @(negedge CLK_68KCLK);
      if (!nBGACK) found = 1;
    end
    check("grant_after_as", found, 1);
    found = 0;
    for (k = 0; k < 50 && !found; k++) begin
      @(negedge CLK_68KCLK);
      if (!nDMA_AS && !DMA_RW && wq_a.size() == 3) found = 1;
    end
    check("in_wr_w", found, 1);
    nRESET = 1'b0;
    #1;
    check("async_rst_ctrl", {nBR, nBGACK, nDMA_AS, nDMA_UDS, nDMA_LDS, DMA_RW,
                             DMA_DRIVE, DMA_DOE, DMA_BUSY, DMA_DONE, DMA_ERR}, 11'b11111100000);
    check("async_rst_addr", {9'd0, DMA_ADDR}, 0);
    check("async_rst_dout", {16'd0, DMA_DOUT}, 0);
    @(negedge CLK_68KCLK);
    nRESET = 1'b1;
    grant_delay = 1;
    run_xfer("post_rst", 1'b1, 32'h0, 32'h0050_0000, 32'h0000_0F0F, 32'd2, 2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cd_dma_ctrl.md
Name: cd_dma_ctrl

Overview:
- Bus-master DMA sequencer for the NeoGeo CD system block.
- Takes the already-latched DMA source, destination, fill value and word count plus a mode, then performs the transfer on the 68K bus. It arbitrates with the CPU via nBR/nBG/nBGACK.
- Mode 0 copies words from source to destination; mode 1 fills the destination with VALUE[15:0].
- Signals completion to the CD IRQ logic with a one-cycle done pulse.

Parameters:
- DTACK_TIMEOUT, 64: CLK_68KCLK cycles to wait for nDTACK in one bus cycle before aborting with error.
- CNT_W, 24: width of the internal word counter; DMA_COUNT bits above CNT_W are ignored.

Ports:
- CLK_68KCLK  in  1  system clock (68K clock domain).
- nRESET  in  1  asynchronous active-low reset.
- DMA_START  in  1  one-cycle pulse; starts a transfer when idle, ignored otherwise.
- DMA_ABORT  in  1  level; finish the current bus cycle, then release the bus.
- DMA_MODE  in  1  0=copy, 1=fill.
- DMA_SOURCE  in  32  byte address; bits [23:1] used.
- DMA_DEST  in  32  byte address; bits [23:1] used.
- DMA_VALUE  in  32  fill word in [15:0].
- DMA_COUNT  in  32  number of 16-bit words.
- nBR  out  1  bus request.
- nBG  in  1  bus grant from CPU.
- nAS_CPU  in  1  CPU address strobe, used to detect the end of the CPU cycle.
- nBGACK  out  1  bus grant acknowledge.
- DMA_ADDR  out  23  address [23:1].
- DMA_DOUT  out  16  write data.
- DMA_DIN  in  16  read data.
- DMA_DRIVE  out  1  high while this block owns the address/strobe/RW lines.
- DMA_DOE  out  1  high when DMA_DOUT must drive the data bus.
- nDMA_AS, nDMA_UDS, nDMA_LDS, DMA_RW  out  1 each  bus strobes.
- nDTACK  in  1  data acknowledge.
- DMA_BUSY  out  1  high from accepted start until back in IDLE.
- DMA_DONE  out  1  one-cycle pulse on completion (normal, aborted or error).
- DMA_ERR  out  1  sticky timeout flag; cleared by the next accepted DMA_START.

Behaviour:
- Reset values: nBR=1, nBGACK=1, nDMA_AS/UDS/LDS=1, DMA_RW=1, DMA_DRIVE=0, DMA_DOE=0, DMA_ADDR=0, DMA_DOUT=0, DMA_BUSY=0, DMA_DONE=0, DMA_ERR=0, state=IDLE. Reset mid-transfer returns to IDLE immediately and releases the bus.
- On an accepted start, latch: SRC=DMA_SOURCE[23:1], DST=DMA_DEST[23:1], CNT=DMA_COUNT[CNT_W-1:0], MODE, VALUE. Inputs are not sampled again for that transfer.
- States:
  - IDLE: on DMA_START, latch, set BUSY, clear ERR. If CNT==0, go to FINISH with no bus activity. Else go to REQ.
  - REQ: nBR=0. Wait for nBG==0 && nAS_CPU==1 in the same cycle, then GRANT.
  - GRANT: nBGACK=0, nBR=1, DRIVE=1. Next state is RD_A if MODE==0, else WR_A.
  - RD_A: ADDR=SRC, RW=1, nAS/UDS/LDS=0, timer=0, go to RD_W.
  - RD_W: on nDTACK==0, latch DMA_DIN into DOUT, negate strobes, go to WR_A. If timer reaches DTACK_TIMEOUT, negate strobes, set ERR, go to REL.
  - WR_A: ADDR=DST, RW=0, DOE=1, DOUT=data (fill: VALUE[15:0]), strobes=0, go to WR_W.
  - WR_W: on nDTACK==0, negate strobes, DOE=0, go to NEXT. Timeout handled as in RD_W.
  - NEXT: CNT-=1; DST+=1; SRC+=1 (copy only), word units, wrapping modulo 2^23. If CNT becomes 0 or DMA_ABORT==1, go to REL; else RD_A/WR_A per mode.
  - REL: DRIVE=0, nBGACK=1, go to FINISH.
  - FINISH: DONE=1 for one cycle, BUSY=0, go to IDLE.
- Strobes and RW change only in _A states or on leaving _W states. At least one cycle with strobes high separates consecutive bus cycles.
- DMA_ABORT is sampled only in NEXT and never truncates a bus cycle. An abort asserted before the grant still waits for the grant, then releases after the first word.
- DMA_START while BUSY is ignored.
- Timer width is clog2(DTACK_TIMEOUT)+1; it resets in every _A state.
- Throughput, zero-wait memory: fill = 3 cycles/word, copy = 5 cycles/word.

Decomposition:
- Shared package cd_pkg:
  - state enum (IDLE, REQ, GRANT, RD_A, RD_W, WR_A, WR_W, NEXT, REL, FINISH);
  - mode constants DMA_MODE_COPY=0, DMA_MODE_FILL=1;
  - CD register address constants (FF0061, FF0064..FF0073).
- One natural sub-module: cd_dma_busreq, containing the REQ/GRANT/REL handshake FSM, a bus_owned output and a release input. The transfer FSM stays in cd_dma_ctrl.

Test Plan:
- Fill, mode 1: DEST=0x100000, VALUE=0xABCD, COUNT=4, nBG low 2 cycles after nBR, nDTACK immediate -> 4 writes to word addr 0x080000..0x080003, all data 0xABCD; one DONE pulse; ERR=0; nBGACK high afterwards.
- Copy, mode 0: SRC=0x200000 returning 0x1111, 0x2222, 0x3333; DEST=0xE00000; COUNT=3 -> alternating read/write; writes carry 0x1111, 0x2222, 0x3333 to 0x700000..0x700002.
- COUNT=0 -> nBR never asserted; DONE exactly 2 cycles after DMA_START.
- nDTACK never asserted, COUNT=2 -> after 64 cycles in RD_W strobes negate, ERR=1, bus released, DONE pulses; next START clears ERR.
- DMA_ABORT raised during the 2nd write of COUNT=10 -> exactly 2 writes complete, then REL; DONE pulses once.
- nAS_CPU held low 5 cycles after nBG falls -> GRANT is delayed until nAS_CPU rises; asynchronous reset in WR_W -> all outputs at reset values immediately.
